// File: rtl/serv_bus_arbiter.sv
// serv_bus_arbiter: shares one Wishbone master port between SERV ibus and dbus.
// Registered round-robin grant, per-transfer lock and a no-ack watchdog.
module serv_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_timeout
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LAST =
        (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam bit WDOG_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IBUS,
        S_DBUS
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          last_d;
    logic          last_d_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [31:0]   adr_n;
    logic [31:0]   dat_n;
    logic [3:0]    sel_n;
    logic          we_n;
    logic          cyc_n;
    logic          pick_d;
    logic          req;
    logic          expire;
    logic          done;
    logic [31:0]   rdt;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            last_d   <= 1'b0;
            cnt      <= '0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
            o_wb_sel <= '0;
            o_wb_we  <= 1'b0;
            o_wb_cyc <= 1'b0;
        end else begin
            state    <= state_n;
            last_d   <= last_d_n;
            cnt      <= cnt_n;
            o_wb_adr <= adr_n;
            o_wb_dat <= dat_n;
            o_wb_sel <= sel_n;
            o_wb_we  <= we_n;
            o_wb_cyc <= cyc_n;
        end
    end

    always_comb begin
        state_n    = state;
        last_d_n   = last_d;
        cnt_n      = cnt;
        adr_n      = o_wb_adr;
        dat_n      = o_wb_dat;
        sel_n      = o_wb_sel;
        we_n       = o_wb_we;
        cyc_n      = o_wb_cyc;
        o_ibus_ack = 1'b0;
        o_dbus_ack = 1'b0;
        o_ibus_rdt = i_wb_rdt;
        o_dbus_rdt = i_wb_rdt;
        o_timeout  = 1'b0;
        pick_d     = i_dbus_cyc & (~i_ibus_cyc | ~last_d);
        req        = (state == S_DBUS) ? i_dbus_cyc : i_ibus_cyc;
        expire     = WDOG_EN && (cnt == CNT_LAST);
        done       = 1'b0;
        rdt        = i_wb_rdt;

        unique case (state)
            S_IDLE: begin
                if (i_ibus_cyc | i_dbus_cyc) begin
                    cyc_n    = 1'b1;
                    cnt_n    = '0;
                    last_d_n = pick_d;
                    if (pick_d) begin
                        state_n = S_DBUS;
                        adr_n   = i_dbus_adr;
                        dat_n   = i_dbus_dat;
                        sel_n   = i_dbus_sel;
                        we_n    = i_dbus_we;
                    end else begin
                        state_n = S_IBUS;
                        adr_n   = i_ibus_adr;
                        dat_n   = '0;
                        sel_n   = 4'hf;
                        we_n    = 1'b0;
                    end
                end
            end
            S_IBUS, S_DBUS: begin
                // a real ack beats both abort and watchdog expiry
                if (i_wb_ack) begin
                    done = 1'b1;
                end else if (!req) begin
                    state_n = S_IDLE;
                    cyc_n   = 1'b0;
                end else if (expire) begin
                    done      = 1'b1;
                    rdt       = ERR_DATA;
                    o_timeout = 1'b1;
                end else if (WDOG_EN && (cnt != CNT_MAX)) begin
                    cnt_n = cnt + 1'b1;
                end
                if (done) begin
                    state_n = S_IDLE;
                    cyc_n   = 1'b0;
                    if (state == S_DBUS) begin
                        o_dbus_ack = 1'b1;
                        o_dbus_rdt = rdt;
                    end else begin
                        o_ibus_ack = 1'b1;
                        o_ibus_rdt = rdt;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                cyc_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// tb_serv_bus_arbiter: randomized scoreboard bench for serv_bus_arbiter.
// Driver acts as both masters and the slave; a monitor checks every ack.
module tb_serv_bus_arbiter;

    localparam int          TMO = 8;
    localparam logic [31:0] ERR = 32'hBAD0_0BAD;

    logic        clk;
    logic        rst_n;
    logic [31:0] ibus_adr;
    logic        ibus_cyc;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic [31:0] dbus_adr;
    logic [31:0] dbus_dat;
    logic [3:0]  dbus_sel;
    logic        dbus_we;
    logic        dbus_cyc;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        timeout;

    serv_bus_arbiter #(
        .TIMEOUT (TMO),
        .ERR_DATA(ERR)
    ) dut (
        .clk       (clk),
        .i_rst_n   (rst_n),
        .i_ibus_adr(ibus_adr),
        .i_ibus_cyc(ibus_cyc),
        .o_ibus_rdt(ibus_rdt),
        .o_ibus_ack(ibus_ack),
        .i_dbus_adr(dbus_adr),
        .i_dbus_dat(dbus_dat),
        .i_dbus_sel(dbus_sel),
        .i_dbus_we (dbus_we),
        .i_dbus_cyc(dbus_cyc),
        .o_dbus_rdt(dbus_rdt),
        .o_dbus_ack(dbus_ack),
        .o_wb_adr  (wb_adr),
        .o_wb_dat  (wb_dat),
        .o_wb_sel  (wb_sel),
        .o_wb_we   (wb_we),
        .o_wb_cyc  (wb_cyc),
        .i_wb_rdt  (wb_rdt),
        .i_wb_ack  (wb_ack),
        .o_timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          we;
        logic [31:0] rdt;
        bit          to;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   model_last_d;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // monitor: every completion must match the oldest expected one
    exp_t e;
    always @(negedge clk) begin
        if (rst_n && (ibus_ack || dbus_ack || timeout)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_ack: got i=%b d=%b to=%b expected none",
                         ibus_ack, dbus_ack, timeout);
            end else begin
                e = sb.pop_front();
                chk("ack_who", {30'd0, ibus_ack, dbus_ack},
                    e.is_d ? 32'd1 : 32'd2);
                chk("ack_rdt", e.is_d ? dbus_rdt : ibus_rdt, e.rdt);
                chk("ack_tmo", {31'd0, timeout}, {31'd0, e.to});
                chk("ack_adr", wb_adr, e.adr);
                chk("ack_sel", {28'd0, wb_sel}, {28'd0, e.sel});
                chk("ack_we", {31'd0, wb_we}, {31'd0, e.we});
                if (e.is_d) chk("ack_dat", wb_dat, e.dat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // slave side of one granted transfer; entered in the first granted cycle
    task automatic serve(input bit is_d, input int dly,
                         input logic [31:0] rdt, input logic [31:0] eadr);
        int last;
        last = (dly < TMO) ? dly : TMO - 1;
        chk("grant_cyc", {31'd0, wb_cyc}, 32'd1);
        for (int k = 0; k <= last; k++) begin
            wb_rdt = rdt;
            wb_ack = (k == dly);
            chk("hold_adr", wb_adr, eadr);
            tick();
        end
        wb_ack = 1'b0;
        wb_rdt = $urandom;
        if (is_d) dbus_cyc = 1'b0;
        else      ibus_cyc = 1'b0;
        chk("post_cyc", {31'd0, wb_cyc}, 32'd0);
    endtask

    function automatic exp_t mk(input bit is_d, input logic [31:0] ia,
                                input logic [31:0] da, input logic [31:0] dt,
                                input logic [3:0] s, input bit w,
                                input int dly, input logic [31:0] r);
        exp_t x;
        x.is_d = is_d;
        x.adr  = is_d ? da : ia;
        x.dat  = dt;
        x.sel  = is_d ? s : 4'hf;
        x.we   = is_d ? w : 1'b0;
        x.to   = (dly >= TMO);
        x.rdt  = x.to ? ERR : r;
        return x;
    endfunction

    task automatic run_txn(input bit ir, input bit dr,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] dt, input logic [3:0] s,
                           input bit w, input int di, input int dd);
        bit          first_d;
        logic [31:0] ri;
        logic [31:0] rd;
        ri = $urandom;
        rd = $urandom;
        ibus_adr = ia;
        dbus_adr = da;
        dbus_dat = dt;
        dbus_sel = s;
        dbus_we  = w;
        ibus_cyc = ir;
        dbus_cyc = dr;
        first_d  = (ir && dr) ? !model_last_d : dr;
        if (first_d) sb.push_back(mk(1'b1, ia, da, dt, s, w, dd, rd));
        else         sb.push_back(mk(1'b0, ia, da, dt, s, w, di, ri));
        if (ir && dr) begin
            if (first_d) sb.push_back(mk(1'b0, ia, da, dt, s, w, di, ri));
            else         sb.push_back(mk(1'b1, ia, da, dt, s, w, dd, rd));
        end
        tick();
        model_last_d = first_d;
        if (first_d) serve(1'b1, dd, rd, da);
        else         serve(1'b0, di, ri, ia);
        if (ir && dr) begin
            tick();
            model_last_d = !first_d;
            if (first_d) serve(1'b0, di, ri, ia);
            else         serve(1'b1, dd, rd, da);
        end
    endtask

    function automatic int rnd_dly();
        return ($urandom_range(0, 3) == 0) ? $urandom_range(7, 8)
                                           : $urandom_range(0, 11);
    endfunction

    initial begin
        rst_n    = 1'b0;
        ibus_adr = '0;
        ibus_cyc = 1'b0;
        dbus_adr = '0;
        dbus_dat = '0;
        dbus_sel = '0;
        dbus_we  = 1'b0;
        dbus_cyc = 1'b0;
        wb_rdt   = '0;
        wb_ack   = 1'b0;
        model_last_d = 1'b0;
        tick();
        tick();
        chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
        chk("rst_adr", wb_adr, 32'd0);
        chk("rst_dat", wb_dat, 32'd0);
        chk("rst_sel", {28'd0, wb_sel}, 32'd0);
        chk("rst_we", {31'd0, wb_we}, 32'd0);
        chk("rst_acks", {30'd0, ibus_ack, dbus_ack}, 32'd0);
        chk("rst_tmo", {31'd0, timeout}, 32'd0);
        rst_n = 1'b1;
        tick();

        // first tie after reset goes to dbus, then alternates
        run_txn(1, 1, 32'h40, 32'h80, 32'h1111_2222, 4'hf, 1'b0, 1, 2);
        run_txn(1, 1, 32'h44, 32'h84, 32'h3333_4444, 4'h1, 1'b1, 0, 3);
        tick();
        run_txn(1, 0, 32'h100, 32'h0, 32'h0, 4'h0, 1'b0, 2, 0);
        tick();
        run_txn(0, 1, 32'h0, 32'h2004, 32'hDEAD_BEEF, 4'b0011, 1'b1, 0, 3);
        tick();
        run_txn(0, 1, 32'h0, 32'h3000, 32'h0, 4'hf, 1'b0, 0, 40);
        tick();
        run_txn(0, 1, 32'h0, 32'h3004, 32'h0, 4'hf, 1'b0, 0, 7);
        tick();
        run_txn(1, 0, 32'h200, 32'h0, 32'h0, 4'h0, 1'b0, 8, 0);
        tick();
        run_txn(1, 0, 32'h204, 32'h0, 32'h0, 4'h0, 1'b0, 7, 0);

        // abort: dbus drops its request before any ack
        tick();
        dbus_adr = 32'h5000;
        dbus_cyc = 1'b1;
        tick();
        model_last_d = 1'b1;
        chk("abort_grant", {31'd0, wb_cyc}, 32'd1);
        tick();
        dbus_cyc = 1'b0;
        tick();
        chk("abort_cyc", {31'd0, wb_cyc}, 32'd0);

        // ack while idle must not reach either master
        wb_ack = 1'b1;
        tick();
        tick();
        wb_ack = 1'b0;
        chk("idle_cyc", {31'd0, wb_cyc}, 32'd0);
        run_txn(1, 1, 32'h60, 32'h64, 32'h5555_6666, 4'hc, 1'b1, 1, 1);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] m;
            m = 2'($urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) tick();
            run_txn(m[0], m[1], $urandom, $urandom, $urandom,
                    4'($urandom), 1'($urandom), rnd_dly(), rnd_dly());
        end

        // reset in the middle of a dbus transfer
        tick();
        dbus_adr = 32'h7000;
        dbus_cyc = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cyc", {31'd0, wb_cyc}, 32'd0);
        chk("arst_adr", wb_adr, 32'd0);
        dbus_cyc = 1'b0;
        tick();
        #2;
        rst_n = 1'b1;
        model_last_d = 1'b0;
        tick();
        run_txn(1, 1, 32'h90, 32'h94, 32'h7777_8888, 4'h6, 1'b1, 2, 1);

        tick();
        tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
